// File: rtl/currency_accumulator_mc.sv
// currency_accumulator_mc: multi-slot currency validation with saturating credit, reject and refund handling
module currency_accumulator_mc #(
    parameter int NUM_CH = 2,
    parameter int CURRENCY_WIDTH = 8,
    parameter int TOTAL_WIDTH = 15,
    parameter int NUM_DENOM = 6,
    parameter logic [NUM_DENOM*CURRENCY_WIDTH-1:0] DENOM_LIST = {8'd100, 8'd50, 8'd20, 8'd15, 8'd10, 8'd5},
    parameter int MAX_TOTAL = 25500
) (
    input  logic clk,
    input  logic rst,
    input  logic [NUM_CH*CURRENCY_WIDTH-1:0] currency_in,
    input  logic [NUM_CH-1:0] currency_valid_pulse,
    input  logic accept_en,
    input  logic dispense_valid,
    input  logic cancel,
    output logic currency_done,
    output logic [TOTAL_WIDTH-1:0] total_amount,
    output logic reject_valid,
    output logic [CURRENCY_WIDTH+$clog2(NUM_CH+1)-1:0] reject_amount,
    output logic refund_valid,
    output logic [TOTAL_WIDTH-1:0] refund_amount,
    output logic [1:0] state
);
    localparam int SW = TOTAL_WIDTH + 1;
    localparam int RW = CURRENCY_WIDTH + $clog2(NUM_CH + 1);
    localparam logic [SW-1:0] MAX_S = SW'(MAX_TOTAL);
    typedef enum logic [1:0] {IDLE, CREDIT, REFUND} state_t;
    state_t cur, nxt;
    logic [SW-1:0] run;
    logic [RW-1:0] rej_sum;
    logic [NUM_CH-1:0] acc, rej;
    logic [CURRENCY_WIDTH-1:0] v;
    logic hit, open, refund;
    logic [TOTAL_WIDTH-1:0] nxt_total;
    // slots are admitted in ascending order against the running sum so credit never exceeds MAX_TOTAL
    always_comb begin
        open = accept_en && cur != REFUND && !dispense_valid && !cancel;
        run = SW'(total_amount);
        rej_sum = '0;
        acc = '0;
        rej = '0;
        v = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            v = currency_in[i*CURRENCY_WIDTH +: CURRENCY_WIDTH];
            hit = 1'b0;
            for (int j = 0; j < NUM_DENOM; j++)
                hit = hit | (v == DENOM_LIST[j*CURRENCY_WIDTH +: CURRENCY_WIDTH]);
            if (currency_valid_pulse[i]) begin
                if (hit && open && run + SW'(v) <= MAX_S) begin
                    acc[i] = 1'b1;
                    run = run + SW'(v);
                end else begin
                    rej[i] = 1'b1;
                    rej_sum = rej_sum + RW'(v);
                end
            end
        end
    end
    always_comb begin
        refund = cur == CREDIT && cancel && !dispense_valid;
        nxt_total = (dispense_valid || cancel) ? '0 : run[TOTAL_WIDTH-1:0];
        nxt = cur == REFUND ? IDLE :
              cur == CREDIT ? (dispense_valid ? IDLE : cancel ? REFUND : CREDIT) :
              (|acc ? CREDIT : IDLE);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= IDLE;
            total_amount <= '0;
            currency_done <= 1'b0;
            reject_valid <= 1'b0;
            reject_amount <= '0;
            refund_valid <= 1'b0;
            refund_amount <= '0;
        end else begin
            cur <= nxt;
            total_amount <= nxt_total;
            currency_done <= |acc;
            reject_valid <= |rej;
            reject_amount <= rej_sum;
            refund_valid <= refund;
            if (refund) refund_amount <= total_amount;
        end
    end
    assign state = cur;
endmodule

// File: tb/tb_currency_accumulator_mc.sv
// tb_currency_accumulator_mc: directed self-checking bench for currency_accumulator_mc
module tb_currency_accumulator_mc;
    logic clk = 1'b0;
    logic rst;
    logic [15:0] currency_in;
    logic [1:0] currency_valid_pulse;
    logic accept_en, dispense_valid, cancel;
    logic currency_done, reject_valid, refund_valid;
    logic [14:0] total_amount, refund_amount;
    logic [9:0] reject_amount;
    logic [1:0] state;
    int checks = 0;
    int errors = 0;

    currency_accumulator_mc dut (
        .clk(clk),
        .rst(rst),
        .currency_in(currency_in),
        .currency_valid_pulse(currency_valid_pulse),
        .accept_en(accept_en),
        .dispense_valid(dispense_valid),
        .cancel(cancel),
        .currency_done(currency_done),
        .total_amount(total_amount),
        .reject_valid(reject_valid),
        .reject_amount(reject_amount),
        .refund_valid(refund_valid),
        .refund_amount(refund_amount),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [7:0] v0, input logic s0, input logic [7:0] v1, input logic s1,
                       input logic dv, input logic cn);
        currency_in = {v1, v0};
        currency_valid_pulse = {s1, s0};
        dispense_valid = dv;
        cancel = cn;
        @(posedge clk);
        #1;
        currency_valid_pulse = 2'b00;
        dispense_valid = 1'b0;
        cancel = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        currency_in = '0;
        currency_valid_pulse = '0;
        accept_en = 1'b1;
        dispense_valid = 1'b0;
        cancel = 1'b0;
        #12;
        chk("rst_total", total_amount, 0);
        chk("rst_state", state, 0);
        chk("rst_flags", {currency_done, reject_valid, refund_valid}, 0);
        chk("rst_amounts", {reject_amount, refund_amount}, 0);
        rst = 1'b0;

        cyc(50, 1, 20, 1, 0, 0);
        chk("dual_total", total_amount, 70);
        chk("dual_done", currency_done, 1);
        chk("dual_rejv", reject_valid, 0);
        chk("dual_state", state, 1);

        cyc(7, 1, 0, 0, 0, 0);
        chk("bad_rejv", reject_valid, 1);
        chk("bad_amt", reject_amount, 7);
        chk("bad_total", total_amount, 70);
        chk("bad_done", currency_done, 0);

        accept_en = 1'b0;
        cyc(0, 0, 100, 1, 0, 0);
        chk("lock_amt", reject_amount, 100);
        chk("lock_total", total_amount, 70);
        cyc(100, 1, 100, 1, 0, 0);
        chk("lock_sum", reject_amount, 200);
        accept_en = 1'b1;

        cyc(0, 1, 0, 0, 0, 0);
        chk("zero_rejv", reject_valid, 1);
        chk("zero_amt", reject_amount, 0);
        cyc(7, 1, 3, 1, 0, 0);
        chk("two_bad_amt", reject_amount, 10);
        cyc(0, 0, 0, 0, 0, 0);
        chk("pulse_clear", {currency_done, reject_valid, reject_amount}, 0);

        cyc(0, 0, 0, 0, 1, 0);
        chk("disp_total", total_amount, 0);
        chk("disp_state", state, 0);

        for (int k = 0; k < 127; k++) cyc(100, 1, 100, 1, 0, 0);
        chk("fill_total", total_amount, 25400);
        cyc(50, 1, 0, 0, 0, 0);
        chk("fill2_total", total_amount, 25450);
        cyc(50, 1, 20, 1, 0, 0);
        chk("sat_total", total_amount, 25500);
        chk("sat_done", currency_done, 1);
        chk("sat_rej", {reject_valid, reject_amount}, {1'b1, 10'd20});
        cyc(5, 1, 0, 0, 0, 0);
        chk("full_total", total_amount, 25500);
        chk("full_rej", reject_amount, 5);

        cyc(0, 0, 0, 0, 1, 0);
        chk("disp2_total", total_amount, 0);
        cyc(50, 1, 20, 1, 0, 0);
        cyc(15, 1, 0, 0, 0, 0);
        chk("pre_cancel", total_amount, 85);
        cyc(10, 1, 0, 0, 0, 1);
        chk("cxl_refv", refund_valid, 1);
        chk("cxl_refamt", refund_amount, 85);
        chk("cxl_rej", reject_amount, 10);
        chk("cxl_total", total_amount, 0);
        chk("cxl_state", state, 2);
        cyc(0, 0, 5, 1, 0, 0);
        chk("refst_state", state, 0);
        chk("refst_rej", {reject_valid, reject_amount}, {1'b1, 10'd5});
        chk("refst_refv", refund_valid, 0);
        chk("refst_hold", refund_amount, 85);
        chk("refst_total", total_amount, 0);

        cyc(20, 1, 10, 1, 0, 0);
        chk("pre_both", total_amount, 30);
        cyc(0, 0, 0, 0, 1, 1);
        chk("both_total", total_amount, 0);
        chk("both_refv", refund_valid, 0);
        chk("both_state", state, 0);
        chk("both_hold", refund_amount, 85);
        cyc(0, 0, 0, 0, 0, 1);
        chk("idle_cxl", {refund_valid, state}, 0);

        cyc(50, 1, 10, 1, 0, 0);
        chk("pre_rst", total_amount, 60);
        #3 rst = 1'b1;
        #1;
        chk("arst_total", total_amount, 0);
        chk("arst_state", state, 0);
        chk("arst_refund", {refund_valid, refund_amount}, 0);
        chk("arst_flags", {currency_done, reject_valid, reject_amount}, 0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/currency_accumulator_mc.md
Name: currency_accumulator_mc

Overview:
Multi-channel successor to the single-slot currency input stage. It accepts currency from NUM_CH independent slots (coin, note, …). Each insertion is checked against a parametrised denomination list. Valid credit accumulates into a saturating running total; invalid or overflowing inputs are returned immediately, and the user can cancel for a full refund. It sits between the slot synchronisers and the product-select/dispense controller.

Parameters:
NUM_CH, 2, number of input slots.
CURRENCY_WIDTH, 8, width of one slot value.
TOTAL_WIDTH, 15, width of the running total.
NUM_DENOM, 6, number of entries in DENOM_LIST.
DENOM_LIST, {8'd100,8'd50,8'd20,8'd15,8'd10,8'd5}, packed NUM_DENOM*CURRENCY_WIDTH accepted values; entry 0 is in the LSBs.
MAX_TOTAL, 25500, highest credit held; must be ≤ 2^TOTAL_WIDTH-1.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
currency_in  in  NUM_CH*CURRENCY_WIDTH  per-slot value; slot i occupies bits [i*CURRENCY_WIDTH +: CURRENCY_WIDTH].
currency_valid_pulse  in  NUM_CH  1-cycle strobe per slot; value is sampled only on the strobe.
accept_en  in  1  1 = accept currency; 0 = reject all inserts (machine locked).
dispense_valid  in  1  item dispensed; clear credit.
cancel  in  1  user refund request.
currency_done  out  1  1-cycle pulse: at least one insert was accepted in the previous cycle.
total_amount  out  TOTAL_WIDTH  current credit.
reject_valid  out  1  1-cycle pulse: at least one insert was rejected.
reject_amount  out  CURRENCY_WIDTH+$clog2(NUM_CH+1)  sum of the values rejected that cycle.
refund_valid  out  1  1-cycle pulse on cancel refund.
refund_amount  out  TOTAL_WIDTH  credit returned; held until the next refund.
state  out  2  FSM state: 0 IDLE, 1 CREDIT, 2 REFUND.

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, internal sums cleared.
- Latency: every response is registered, one cycle after the inputs are sampled.
- Slot i is a valid insert when its strobe is 1 AND its value equals some DENOM_LIST entry.
- Slot i is accepted when it is a valid insert AND accept_en=1 AND state≠REFUND AND dispense_valid=0 AND cancel=0 AND the running sum still fits.
- "Still fits" is evaluated in ascending slot order: total_amount plus all previously accepted slots plus slot i ≤ MAX_TOTAL.
- Every strobed slot that is not accepted is rejected: its value is added to reject_amount and reject_valid=1. Value 0 is rejected when it is not in the list.
- Credit is never lost or truncated. Internal sum width is TOTAL_WIDTH+1, so no wrap-around is possible.
- FSM transitions:
  - IDLE: enter CREDIT when any insert is accepted. cancel is ignored; dispense_valid holds IDLE.
  - CREDIT: on dispense_valid, total←0 and go to IDLE. On cancel (with dispense_valid=0), refund_amount←total, refund_valid=1, total←0, go to REFUND. Otherwise add the accepted sum.
  - REFUND: lasts exactly 1 cycle, rejects all strobes, then goes to IDLE.
- dispense_valid and cancel asserted together: dispense wins and no refund occurs.
- Inserts in the same cycle as dispense_valid or cancel are rejected, never silently dropped.
- Pulsed outputs (currency_done, reject_valid, refund_valid) return to 0 in the next cycle unless retriggered.
- reject_amount is 0 in any cycle where reject_valid=0.
- Reset mid-operation discards credit with no refund pulse.

Test Plan:
- Reset, then slot0=50 and slot1=20 in the same cycle → next cycle total=70, currency_done=1, reject_valid=0, state=CREDIT.
- slot0=7 → reject_valid=1, reject_amount=7, total unchanged; slot1=100 with accept_en=0 → reject_amount=100.
- total=25450, slot0=50 and slot1=20 together → slot0 accepted, total=25500; slot1 rejected, reject_amount=20.
- total=85, then cancel with slot0=10 in the same cycle → refund_valid=1, refund_amount=85, reject_amount=10, total=0; state goes REFUND then IDLE.
- total=30, dispense_valid and cancel together → total=0, refund_valid=0, state=IDLE.
- Assert rst asynchronously mid-cycle with total=60 → all outputs 0 immediately, no refund pulse.
